mrh_l2_req_arb: RTL and testbench

MRH_L2_REQ_ARB -- requirements
Module: mrh_l2_req_arb

---
 rtl/mrh_l2_req_arb.sv | 172 +++++++++++++++++
 tb/tb_mrh_l2_req_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrh_l2_req_arb.sv
// mrh_l2_req_arb: arbitrates REQ_PORT_NUM clients onto a single tagged L2 request
// channel and routes tagged L2 responses back to the client that owns the tag.
//
// Ports:
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready        per-client handshake (ready is one-hot or zero, combinational)
//   i_req_cmd/addr/data/byte_en      per-client request payload
//   o_resp_valid / o_resp_data       per-client response pulse, shared response data
//   o_l2_req_valid / i_l2_req_ready  L2 request handshake
//   o_l2_req_cmd/addr/tag/data/byte_en  registered L2 request payload
//   i_l2_resp_valid/tag/data         L2 response
//   o_busy                           a tag is outstanding or an L2 request is pending
//   o_spurious_resp                  pulse for a response whose tag is not outstanding
module mrh_l2_req_arb #(
  parameter int unsigned REQ_PORT_NUM = 2,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned ADDR_W       = 56
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic [REQ_PORT_NUM-1:0]             i_req_valid,
  output logic [REQ_PORT_NUM-1:0]             o_req_ready,
  input  logic [REQ_PORT_NUM-1:0][4:0]        i_req_cmd,
  input  logic [REQ_PORT_NUM-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [REQ_PORT_NUM-1:0][DATA_W-1:0] i_req_data,
  input  logic [REQ_PORT_NUM-1:0][DATA_W/8-1:0] i_req_byte_en,
  output logic [REQ_PORT_NUM-1:0]             o_resp_valid,
  output logic [DATA_W-1:0]                   o_resp_data,
  output logic                                o_l2_req_valid,
  input  logic                                i_l2_req_ready,
  output logic [4:0]                          o_l2_req_cmd,
  output logic [ADDR_W-1:0]                   o_l2_req_addr,
  output logic [TAG_W-1:0]                    o_l2_req_tag,
  output logic [DATA_W-1:0]                   o_l2_req_data,
  output logic [DATA_W/8-1:0]                 o_l2_req_byte_en,
  input  logic                                i_l2_resp_valid,
  input  logic [TAG_W-1:0]                    i_l2_resp_tag,
  input  logic [DATA_W-1:0]                   i_l2_resp_data,
  output logic                                o_busy,
  output logic                                o_spurious_resp
);

  localparam int unsigned CMD_W   = 5;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned TAG_NUM = 1 << TAG_W;
  localparam int unsigned PORT_W  = (REQ_PORT_NUM > 1) ? $clog2(REQ_PORT_NUM) : 1;

  // Tag table: valid bit and owning port per tag
  logic [TAG_NUM-1:0]             r_tag_vld;
  logic [TAG_NUM-1:0][PORT_W-1:0] r_tag_own;
  logic [PORT_W-1:0]              r_rr;

  logic                    r_l2_req_valid;
  logic [CMD_W-1:0]        r_l2_req_cmd;
  logic [ADDR_W-1:0]       r_l2_req_addr;
  logic [TAG_W-1:0]        r_l2_req_tag;
  logic [DATA_W-1:0]       r_l2_req_data;
  logic [BE_W-1:0]         r_l2_req_byte_en;
  logic [REQ_PORT_NUM-1:0] r_resp_valid;
  logic [DATA_W-1:0]       r_resp_data;
  logic                    r_spurious;
  logic                    r_busy;

  logic                    w_tag_avail;
  logic                    w_out_free;
  logic                    w_can_gnt;
  logic                    w_gnt_vld;
  logic [PORT_W-1:0]       w_gnt_idx;
  logic [PORT_W-1:0]       w_rr_nxt;
  logic                    w_free_found;
  logic [TAG_W-1:0]        w_free_tag;
  logic                    w_resp_hit;
  logic [PORT_W-1:0]       w_resp_own;
  logic [TAG_NUM-1:0]      w_tag_vld_nxt;
  logic                    w_l2_vld_nxt;

  // Grant selection, tag allocation and next table state
  always_comb begin
    w_tag_avail   = ~&r_tag_vld;
    w_out_free    = ~r_l2_req_valid | i_l2_req_ready;
    // Gating with reset keeps ready low even though it is combinational
    w_can_gnt     = w_tag_avail & w_out_free & i_reset_n;
    w_gnt_vld     = 1'b0;
    w_gnt_idx     = '0;
    w_free_found  = 1'b0;
    w_free_tag    = '0;
    w_resp_hit    = i_l2_resp_valid & r_tag_vld[i_l2_resp_tag];
    w_resp_own    = r_tag_own[i_l2_resp_tag];
    w_tag_vld_nxt = r_tag_vld;
    o_req_ready   = '0;

    // Round-robin scan starting at r_rr
    for (int unsigned i = 0; i < REQ_PORT_NUM; i++) begin
      if (!w_gnt_vld && w_can_gnt &&
          i_req_valid[PORT_W'((32'(r_rr) + i) % REQ_PORT_NUM)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PORT_W'((32'(r_rr) + i) % REQ_PORT_NUM);
      end
    end

    // Lowest free tag, from the registered table so a tag freed this cycle is not reused
    for (int unsigned t = 0; t < TAG_NUM; t++) begin
      if (!w_free_found && !r_tag_vld[TAG_W'(t)]) begin
        w_free_found = 1'b1;
        w_free_tag   = TAG_W'(t);
      end
    end

    w_rr_nxt = w_gnt_vld ? PORT_W'((32'(w_gnt_idx) + 32'd1) % REQ_PORT_NUM) : r_rr;

    if (w_gnt_vld) begin
      o_req_ready                = REQ_PORT_NUM'(1) << w_gnt_idx;
      w_tag_vld_nxt[w_free_tag]  = 1'b1;
    end
    // Allocated tag is free at cycle start and the freed tag is valid, so they never collide
    if (w_resp_hit) begin
      w_tag_vld_nxt[i_l2_resp_tag] = 1'b0;
    end

    w_l2_vld_nxt = w_gnt_vld | (r_l2_req_valid & ~i_l2_req_ready);
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tag_vld        <= '0;
      r_tag_own        <= '0;
      r_rr             <= '0;
      r_l2_req_valid   <= 1'b0;
      r_l2_req_cmd     <= '0;
      r_l2_req_addr    <= '0;
      r_l2_req_tag     <= '0;
      r_l2_req_data    <= '0;
      r_l2_req_byte_en <= '0;
      r_resp_valid     <= '0;
      r_resp_data      <= '0;
      r_spurious       <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_tag_vld      <= w_tag_vld_nxt;
      r_rr           <= w_rr_nxt;
      r_l2_req_valid <= w_l2_vld_nxt;
      if (w_gnt_vld) begin
        r_tag_own[w_free_tag] <= w_gnt_idx;
        r_l2_req_cmd          <= i_req_cmd[w_gnt_idx];
        r_l2_req_addr         <= i_req_addr[w_gnt_idx];
        r_l2_req_data         <= i_req_data[w_gnt_idx];
        r_l2_req_byte_en      <= i_req_byte_en[w_gnt_idx];
        r_l2_req_tag          <= w_free_tag;
      end
      r_resp_valid <= w_resp_hit ? (REQ_PORT_NUM'(1) << w_resp_own) : '0;
      if (w_resp_hit) begin
        r_resp_data <= i_l2_resp_data;
      end
      r_spurious <= i_l2_resp_valid & ~w_resp_hit;
      r_busy     <= (|w_tag_vld_nxt) | w_l2_vld_nxt;
    end
  end

  assign o_l2_req_valid   = r_l2_req_valid;
  assign o_l2_req_cmd     = r_l2_req_cmd;
  assign o_l2_req_addr    = r_l2_req_addr;
  assign o_l2_req_tag     = r_l2_req_tag;
  assign o_l2_req_data    = r_l2_req_data;
  assign o_l2_req_byte_en = r_l2_req_byte_en;
  assign o_resp_valid     = r_resp_valid;
  assign o_resp_data      = r_resp_data;
  assign o_spurious_resp  = r_spurious;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_mrh_l2_req_arb.sv
// Self-checking bench for mrh_l2_req_arb: a behavioural model predicts grants,
// tag allocation and responses; expected L2 requests and client responses are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_mrh_l2_req_arb;

  localparam int unsigned N       = 2;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned ADDR_W  = 56;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned TAG_NUM = 16;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [N-1:0]                req_valid;
  logic [N-1:0]                req_ready;
  logic [N-1:0][4:0]           req_cmd;
  logic [N-1:0][ADDR_W-1:0]    req_addr;
  logic [N-1:0][DATA_W-1:0]    req_data;
  logic [N-1:0][BE_W-1:0]      req_be;
  logic [N-1:0]                resp_valid;
  logic [DATA_W-1:0]           resp_data;
  logic                        l2_valid;
  logic                        l2_ready;
  logic [4:0]                  l2_cmd;
  logic [ADDR_W-1:0]           l2_addr;
  logic [TAG_W-1:0]            l2_tag;
  logic [DATA_W-1:0]           l2_data;
  logic [BE_W-1:0]             l2_be;
  logic                        l2_resp_valid;
  logic [TAG_W-1:0]            l2_resp_tag;
  logic [DATA_W-1:0]           l2_resp_data;
  logic                        busy;
  logic                        spur;

  always #5 clk = ~clk;

  mrh_l2_req_arb #(
    .REQ_PORT_NUM(N), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) u_dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_cmd(req_cmd), .i_req_addr(req_addr), .i_req_data(req_data), .i_req_byte_en(req_be),
    .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .o_l2_req_valid(l2_valid), .i_l2_req_ready(l2_ready),
    .o_l2_req_cmd(l2_cmd), .o_l2_req_addr(l2_addr), .o_l2_req_tag(l2_tag),
    .o_l2_req_data(l2_data), .o_l2_req_byte_en(l2_be),
    .i_l2_resp_valid(l2_resp_valid), .i_l2_resp_tag(l2_resp_tag), .i_l2_resp_data(l2_resp_data),
    .o_busy(busy), .o_spurious_resp(spur)
  );

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [4:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } l2_t;

  typedef struct {
    int           due;
    logic [N-1:0] vld;
    logic         spur;
    logic [DATA_W-1:0] data;
  } rsp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [TAG_NUM-1:0] m_vld;
  int                 m_own [TAG_NUM];
  int                 m_rr;
  l2_t                oq [$];
  rsp_t               rq [$];
  int                 gp [$];
  int                 gt [$];
  int                 rem [N];

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic new_payload(input int p);
    req_cmd[p]  = 5'($urandom_range(0, 15));
    req_addr[p] = ADDR_W'({$urandom(), $urandom()});
    req_data[p] = rnd_data();
    req_be[p]   = BE_W'($urandom());
  endtask

  task automatic start_port(input int p, input int n);
    rem[p] = n;
    new_payload(p);
    req_valid[p] = 1'b1;
  endtask

  // One clock: compare at negedge, advance the model, then drive next inputs after posedge
  task automatic step();
    int        g;
    int        p;
    int        ft;
    int        free_tag;
    logic      avail;
    logic      out_free;
    logic [N-1:0] exp_rdy;
    rsp_t      r;
    l2_t       e;
    @(negedge clk);
    cyc++;
    r.vld = '0; r.spur = 1'b0; r.data = '0; r.due = cyc;
    if (rq.size() > 0 && rq[0].due == cyc) r = rq.pop_front();
    check("resp_valid", resp_valid, r.vld);
    check("spurious", spur, r.spur);
    if (r.vld != '0) check("resp_data", resp_data, r.data);
    check("l2_valid", l2_valid, oq.size() != 0);
    if (oq.size() != 0) begin
      check("l2_tag", l2_tag, oq[0].tag);
      check("l2_cmd", l2_cmd, oq[0].cmd);
      check("l2_addr", l2_addr, oq[0].addr);
      check("l2_data", l2_data, oq[0].data);
      check("l2_be", l2_be, oq[0].be);
    end
    check("busy", busy, (m_vld != '0) || (oq.size() != 0));

    avail    = (m_vld != '1);
    out_free = (oq.size() == 0) || l2_ready;
    g = -1;
    if (avail && out_free) begin
      for (int i = 0; i < N; i++) begin
        p = (m_rr + i) % N;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, exp_rdy);

    ft = -1;
    for (int t = TAG_NUM - 1; t >= 0; t--) if (!m_vld[t]) ft = t;

    free_tag = -1;
    if (l2_resp_valid) begin
      r.due = cyc + 1;
      r.data = l2_resp_data;
      if (m_vld[l2_resp_tag]) begin
        r.vld = N'(1) << m_own[l2_resp_tag];
        r.spur = 1'b0;
        free_tag = int'(l2_resp_tag);
      end else begin
        r.vld = '0;
        r.spur = 1'b1;
      end
      rq.push_back(r);
    end

    if (oq.size() != 0 && l2_ready) void'(oq.pop_front());
    if (g >= 0) begin
      m_vld[ft] = 1'b1;
      m_own[ft] = g;
      e.tag = TAG_W'(ft); e.cmd = req_cmd[g]; e.addr = req_addr[g];
      e.data = req_data[g]; e.be = req_be[g];
      oq.push_back(e);
      m_rr = (g + 1) % N;
      gp.push_back(g);
      gt.push_back(ft);
    end
    if (free_tag >= 0) m_vld[free_tag] = 1'b0;

    @(posedge clk);
    #1;
    l2_resp_valid = 1'b0;
    if (g >= 0) begin
      rem[g]--;
      if (rem[g] > 0) new_payload(g);
      else req_valid[g] = 1'b0;
    end
  endtask

  task automatic resp_fire(input int tag, input logic [DATA_W-1:0] d);
    l2_resp_valid = 1'b1;
    l2_resp_tag   = TAG_W'(tag);
    l2_resp_data  = d;
    step();
  endtask

  task automatic stop_ports();
    for (int p = 0; p < N; p++) begin
      rem[p] = 0;
      req_valid[p] = 1'b0;
    end
  endtask

  task automatic drain();
    l2_ready = 1'b1;
    step();
    for (int t = 0; t < TAG_NUM; t++) if (m_vld[t]) resp_fire(t, rnd_data());
    step();
  endtask

  task automatic do_reset();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_l2_valid", l2_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_spurious", spur, 0);
    check("rst_busy", busy, 0);
    check("rst_l2_tag", l2_tag, 0);
    check("rst_l2_addr", l2_addr, 0);
    check("rst_resp_data", resp_data, 0);
    @(posedge clk);
    #1;
    check("rst_hold_ready", req_ready, 0);
    check("rst_hold_l2_valid", l2_valid, 0);
    stop_ports();
    l2_resp_valid = 1'b0;
    m_vld = '0;
    m_rr = 0;
    oq.delete(); rq.delete(); gp.delete(); gt.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_cmd = '0; req_addr = '0; req_data = '0; req_be = '0;
    l2_ready = 1'b1; l2_resp_valid = 1'b0; l2_resp_tag = '0; l2_resp_data = '0;
    m_vld = '0; m_rr = 0;
    for (int p = 0; p < N; p++) rem[p] = 0;
    for (int t = 0; t < TAG_NUM; t++) m_own[t] = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single client read
    start_port(0, 1);
    req_cmd[0]  = 5'h00;
    req_addr[0] = ADDR_W'(64'h8000_0000);
    step();
    check("single_l2_valid", l2_valid, 1);
    check("single_tag", l2_tag, 0);
    check("single_addr", l2_addr, 64'h8000_0000);
    step();
    resp_fire(0, {32{8'hA5}});
    check("single_resp_valid", resp_valid, 2'b01);
    check("single_resp_data", resp_data, {32{8'hA5}});
    check("single_busy_fall", busy, 0);
    step();

    // Fairness from a fresh round-robin pointer
    do_reset();
    start_port(0, 2);
    start_port(1, 2);
    repeat (20) if (gp.size() < 4) step();
    check("fair_cnt", gp.size(), 4);
    if (gp.size() >= 4) begin
      check("fair_p0", gp[0], 0); check("fair_p1", gp[1], 1);
      check("fair_p2", gp[2], 0); check("fair_p3", gp[3], 1);
      check("fair_t0", gt[0], 0); check("fair_t1", gt[1], 1);
      check("fair_t2", gt[2], 2); check("fair_t3", gt[3], 3);
    end
    drain();

    // Spurious response on an empty table
    resp_fire(9, rnd_data());
    check("spur_pulse", spur, 1);
    check("spur_no_resp", resp_valid, 0);
    check("spur_busy", busy, 0);
    step();

    // Backpressure: output register held, no further grants
    gp.delete(); gt.delete();
    l2_ready = 1'b0;
    start_port(1, 3);
    repeat (11) step();
    check("bp_grants", gp.size(), 1);
    l2_ready = 1'b1;
    step();
    check("bp_release_grant", gp.size(), 2);
    repeat (5) if (req_valid != '0) step();
    stop_ports();
    drain();

    // Full table then reuse of a freed tag one cycle later
    gp.delete(); gt.delete();
    start_port(0, 20);
    repeat (24) step();
    check("full_grants", gt.size(), 16);
    check("full_ready", req_ready, 0);
    resp_fire(5, rnd_data());
    check("full_same_cycle", gt.size(), 16);
    step();
    check("full_reuse_cnt", gt.size(), 17);
    if (gt.size() >= 17) check("full_reuse_tag", gt[16], 5);
    stop_ports();
    drain();

    // Mixed random traffic with concurrent responses and grants
    for (int c = 0; c < 60; c++) begin
      for (int p = 0; p < N; p++)
        if (!req_valid[p] && $urandom_range(0, 3) == 0) start_port(p, $urandom_range(1, 3));
      l2_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        l2_resp_valid = 1'b1;
        l2_resp_tag   = TAG_W'($urandom_range(0, 7));
        l2_resp_data  = rnd_data();
      end
      step();
    end
    stop_ports();
    drain();

    // Reset with transactions in flight; late response becomes spurious
    start_port(0, 3);
    repeat (4) step();
    check("mid_busy", busy, 1);
    do_reset();
    resp_fire(1, rnd_data());
    check("mid_spur", spur, 1);
    check("mid_no_resp", resp_valid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
